// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared types and constants for the dmem access sequencer
// Lane geometry and FSM encoding used by dmem_access_ctrl and its lane picker.
package dmem_ctrl_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_lane_pick.sv
// rtl/dmem_lane_pick.sv - lowest-set-bit finder over the pending lane mask
// Purely combinational; grant is one-hot (or zero when nothing is pending).
module dmem_lane_pick
  import dmem_ctrl_pkg::*;
(
  input  logic [NUM_LANES-1:0] mask_i,
  output logic [NUM_LANES-1:0] grant_o,
  output logic [1:0]           idx_o,
  output logic                 any_o
);

  // Scanning from the top down lets the lowest set bit win last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = 2'(i);
      end
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - serialises a 32-bit LSU request into per-bank byte strobes
// One strobe per enabled lane in ascending order; loads assemble bytes into rsp_rdata.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [3:0]        ce_mem,
  output logic [3:0]        we_mem,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [7:0]        bank_wdata,
  input  logic [7:0]        bank_rdata0,
  input  logic [7:0]        bank_rdata1,
  input  logic [7:0]        bank_rdata2,
  input  logic [7:0]        bank_rdata3
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          pend_q, pend_d;
  logic [1:0]          lane_q, lane_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [3:0]          pick_grant;
  logic [1:0]          pick_idx;
  logic                pick_any;
  logic [7:0]          rdata_sel;
  logic [3:0]          pend_left;

  logic                unused_addr;
  assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

  dmem_lane_pick u_pick (
    .mask_i  (pend_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    case (lane_q)
      2'd0:    rdata_sel = bank_rdata0;
      2'd1:    rdata_sel = bank_rdata1;
      2'd2:    rdata_sel = bank_rdata2;
      default: rdata_sel = bank_rdata3;
    endcase
  end

  assign pend_left = pend_q & ~pick_grant;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    pend_d     = pend_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    ce_mem     = '0;
    we_mem     = '0;
    bank_wdata = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr[ADDR_W+1:2];
          wdata_d = req_wdata;
          pend_d  = req_be;
          rdata_d = '0;
          state_d = (|req_be) ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        ce_mem     = pick_grant;
        we_mem     = pick_grant & {NUM_LANES{we_q}};
        bank_wdata = wdata_q[{pick_idx, 3'b000} +: LANE_W];
        pend_d     = pend_left;
        lane_d     = pick_idx;
        cnt_d      = 2'(RD_LAT - 1);
        if (!we_q) begin
          state_d = WAIT;
        end else begin
          state_d = (|pend_left) ? ACCESS : RESP;
        end
      end
      WAIT: begin
        // Bank data is only trusted on the final latency cycle.
        if (cnt_q == 2'd0) begin
          rdata_d[{lane_q, 3'b000} +: LANE_W] = rdata_sel;
          state_d = pick_any ? ACCESS : RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign bank_addr = addr_q;
  assign rsp_rdata = rdata_q;

endmodule
